pio_hex_display_driver: RTL

- Consumes the 16-bit display word written by the HPS into the display PIO and renders it on the DE1-SoC HEX5..HEX0 seven-segment displays.
- Sits directly downstream of the display PIO output port.
- Converts the word to five decimal digits with an iterative double-dabble FSM, one shift per clock, or shows it as four hex nibbles.
- Registers every segment output and updates them atomically, so a conversion in progress never shows intermediate digits.

---
 rtl/pio_hex_display_driver.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pio_hex_display_driver.sv
// pio_hex_display_driver
//   Renders the 16-bit display word from the display PIO on HEX5..HEX0.
//   Decimal mode converts the word to five BCD digits with an iterative
//   double-dabble (one shift per clock); hex mode shows four nibbles.
//   Segment outputs are registered and all change together in one cycle, so
//   a conversion in progress never shows partial digits.
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   value      display word from the PIO out_port
//   hex_mode   0 = unsigned decimal, 1 = hexadecimal
//   hex0..hex4 digit segments, {g,f,e,d,c,b,a}, active-low (hex0 = LSD)
//   hex5       mode indicator (blank in decimal, 'H' in hex)
//   busy       high while a conversion is in flight
//   update     one-cycle pulse on the edge where hex0..hex5 change
module pio_hex_display_driver #(
  parameter bit          BLANK_LEADING = 1'b1,
  parameter int unsigned CONV_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        update
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StConvert = 2'd1;
  localparam logic [1:0] StUpdate  = 2'd2;

  localparam logic [6:0] SegBlank  = 7'h7F;
  localparam logic [6:0] SegH      = 7'h09;
  localparam logic [3:0] CountLast = 4'(CONV_CYCLES - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  logic [15:0]      value_q;
  logic             mode_q;
  logic             in_valid_q;  // value_q/mode_q hold a real sample
  logic [1:0]       state_q, state_d;
  logic [15:0]      work_value_q, work_value_d;
  logic             work_mode_q, work_mode_d;
  logic [19:0]      bcd_q, bcd_d;
  logic [15:0]      shift_q, shift_d;
  logic [3:0]       count_q, count_d;
  logic [15:0]      last_value_q, last_value_d;
  logic             last_mode_q, last_mode_d;
  logic             shown_valid_q, shown_valid_d;
  logic             busy_q, busy_d;
  logic             update_q, update_d;
  logic [5:0][6:0]  seg_q, seg_d;
  logic [5:0][6:0]  seg_next;
  logic [4:0][3:0]  digit;
  logic [2:0]       top_digit;

  // Input stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q    <= '0;
      mode_q     <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      value_q    <= value;
      mode_q     <= hex_mode;
      in_valid_q <= 1'b1;
    end
  end

  // Digit decode of the finished conversion.
  always_comb begin
    digit = work_mode_q ? {4'h0, work_value_q} : bcd_q;
    top_digit = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (digit[i] != 4'h0) top_digit = 3'(i);
    end
    for (int i = 0; i < 5; i++) begin
      if (BLANK_LEADING && (3'(i) > top_digit)) seg_next[i] = SegBlank;
      else                                      seg_next[i] = seg7(digit[i]);
    end
    if (work_mode_q) seg_next[4] = SegBlank;
    seg_next[5] = work_mode_q ? SegH : SegBlank;
  end

  always_comb begin
    state_d       = state_q;
    work_value_d  = work_value_q;
    work_mode_d   = work_mode_q;
    bcd_d         = bcd_q;
    shift_d       = shift_q;
    count_d       = count_q;
    last_value_d  = last_value_q;
    last_mode_d   = last_mode_q;
    shown_valid_d = shown_valid_q;
    busy_d        = busy_q;
    update_d      = 1'b0;
    seg_d         = seg_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_q && (!shown_valid_q || (value_q != last_value_q) ||
                           (mode_q != last_mode_q))) begin
          work_value_d = value_q;
          work_mode_d  = mode_q;
          bcd_d        = '0;
          shift_d      = value_q;
          count_d      = '0;
          busy_d       = 1'b1;
          state_d      = StConvert;
        end
      end
      StConvert: begin
        // Runs in hex mode too so latency does not depend on the mode.
        {bcd_d, shift_d} = {add3(bcd_q), shift_q} << 1;
        count_d = count_q + 4'd1;
        if (count_q == CountLast) state_d = StUpdate;
      end
      StUpdate: begin
        seg_d         = seg_next;
        update_d      = 1'b1;
        busy_d        = 1'b0;
        last_value_d  = work_value_q;
        last_mode_d   = work_mode_q;
        shown_valid_d = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      work_value_q  <= '0;
      work_mode_q   <= 1'b0;
      bcd_q         <= '0;
      shift_q       <= '0;
      count_q       <= '0;
      last_value_q  <= '0;
      last_mode_q   <= 1'b0;
      shown_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      update_q      <= 1'b0;
      seg_q         <= {6{SegBlank}};
    end else begin
      state_q       <= state_d;
      work_value_q  <= work_value_d;
      work_mode_q   <= work_mode_d;
      bcd_q         <= bcd_d;
      shift_q       <= shift_d;
      count_q       <= count_d;
      last_value_q  <= last_value_d;
      last_mode_q   <= last_mode_d;
      shown_valid_q <= shown_valid_d;
      busy_q        <= busy_d;
      update_q      <= update_d;
      seg_q         <= seg_d;
    end
  end

  assign hex0   = seg_q[0];
  assign hex1   = seg_q[1];
  assign hex2   = seg_q[2];
  assign hex3   = seg_q[3];
  assign hex4   = seg_q[4];
  assign hex5   = seg_q[5];
  assign busy   = busy_q;
  assign update = update_q;

endmodule
